// File: rtl/keypad_pkg.sv
// Shared types and key-legend lookup for the 4x4 keypad scan controller.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned ROW_W    = 2;
    localparam int unsigned COL_W    = 2;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ROW_W-1:0] r;
        logic [COL_W-1:0] c;
    } key_pos_t;

    // Hex digit printed on the key at a given matrix position (* = E, # = F).
    function automatic logic [3:0] hex_map(input key_pos_t k);
        logic [3:0] code;
        case ({k.r, k.c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, per-bit, with a
// configurable reset value so idle-high pins do not glitch out of reset.
module sync_2ff #(
    parameter int unsigned           WIDTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: active-low row drive, debounced single-key lock-on,
// one key_valid strobe per press. KEYPAD_HEX_MAP_EN selects legend codes.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEB_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DWELL_W = $clog2(SCAN_DIV) + 1;
    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES) + 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);

    state_t               r_state;
    logic [ROW_W-1:0]     r_row;
    logic [NUM_ROWS-1:0]  r_rows;
    logic [DWELL_W-1:0]   r_dwell;
    logic [DEB_W-1:0]     r_deb;
    key_pos_t             r_cand;
    logic [3:0]           r_key_code;
    logic                 r_key_valid;
    logic                 r_key_held;

    state_t               w_state_nxt;
    logic [ROW_W-1:0]     w_row_nxt;
    logic [DWELL_W-1:0]   w_dwell_nxt;
    logic [DEB_W-1:0]     w_deb_nxt;
    key_pos_t             w_cand_nxt;
    logic [3:0]           w_key_code_nxt;
    logic                 w_key_valid_nxt;
    logic                 w_key_held_nxt;

    logic [NUM_COLS-1:0]  w_cols_sync;
    logic [NUM_COLS-1:0]  w_col_act;
    logic [NUM_COLS-1:0]  w_cand_oh;
    logic                 w_single;
    logic [COL_W-1:0]     w_col_idx;

    sync_2ff #(
        .WIDTH     (NUM_COLS),
        .RESET_VAL ({NUM_COLS{1'b1}})
    ) u_col_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (cols),
        .o_q     (w_cols_sync)
    );

    assign w_col_act = ~w_cols_sync;
    assign w_cand_oh = NUM_COLS'(1) << r_cand.c;
    // Exactly one active column; multi-key patterns are treated as no key.
    assign w_single  = (w_col_act != '0) &&
                       ((w_col_act & (w_col_act - NUM_COLS'(1))) == '0);

    always_comb begin
        w_col_idx = '0;
        case (w_col_act)
            4'b0010: w_col_idx = 2'd1;
            4'b0100: w_col_idx = 2'd2;
            4'b1000: w_col_idx = 2'd3;
            default: w_col_idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_row_nxt       = r_row;
        w_dwell_nxt     = r_dwell;
        w_deb_nxt       = r_deb;
        w_cand_nxt      = r_cand;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = 1'b0;
        w_key_held_nxt  = r_key_held;
        case (r_state)
            SCAN: begin
                if (r_dwell >= DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    if (w_single) begin
                        w_cand_nxt.r = r_row;
                        w_cand_nxt.c = w_col_idx;
                        w_deb_nxt    = '0;
                        w_state_nxt  = DEBOUNCE;
                    end else begin
                        w_row_nxt = r_row + ROW_W'(1);
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DWELL_W'(1);
                end
            end
            DEBOUNCE: begin
                if (w_col_act == w_cand_oh) begin
                    if (r_deb >= DEB_LAST) begin
                        w_state_nxt = PRESSED;
                    end else begin
                        w_deb_nxt = r_deb + DEB_W'(1);
                    end
                end else begin
                    w_state_nxt = SCAN;
                    w_row_nxt   = r_row + ROW_W'(1);
                    w_dwell_nxt = '0;
                end
            end
            PRESSED: begin
`ifdef KEYPAD_HEX_MAP_EN
                w_key_code_nxt = hex_map(r_cand);
`else
                w_key_code_nxt = {r_cand.r, r_cand.c};
`endif
                w_key_valid_nxt = 1'b1;
                w_key_held_nxt  = 1'b1;
                w_deb_nxt       = '0;
                w_state_nxt     = RELEASE;
            end
            RELEASE: begin
                // Any column activity restarts the release window.
                if (w_col_act == '0) begin
                    if (r_deb >= DEB_LAST) begin
                        w_key_held_nxt = 1'b0;
                        w_state_nxt    = SCAN;
                        w_row_nxt      = r_row + ROW_W'(1);
                        w_dwell_nxt    = '0;
                    end else begin
                        w_deb_nxt = r_deb + DEB_W'(1);
                    end
                end else begin
                    w_deb_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row       <= '0;
            r_rows      <= 4'b1110;
            r_dwell     <= '0;
            r_deb       <= '0;
            r_cand      <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_row       <= w_row_nxt;
            r_rows      <= ~(NUM_ROWS'(1) << w_row_nxt);
            r_dwell     <= w_dwell_nxt;
            r_deb       <= w_deb_nxt;
            r_cand      <= w_cand_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_held  <= w_key_held_nxt;
        end
    end

    assign rows      = r_rows;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model drives cols from rows,
// a scoreboard queue holds expected key codes and a monitor checks strobes.
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pk;          // pk[r*4+c] = key at row r, column c is down
    logic [3:0]  exp_q[$];
    logic [3:0]  last_code;
    logic        kv_prev = 1'b0;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_events = 0;
    int          n_exp    = 0;

    keypad_scan_ctrl #(
        .SCAN_DIV   (4),
        .DEB_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Passive switch matrix: a closed key pulls its column low while its row is driven low.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!rows[r])
                for (int c = 0; c < 4; c++)
                    if (pk[r*4+c]) cols[c] = 1'b0;
    end

    function automatic logic [3:0] exp_code(input int r, input int c);
`ifdef KEYPAD_HEX_MAP_EN
        logic [15:0] line;
        case (r)
            0: line = 16'h123A;
            1: line = 16'h456B;
            2: line = 16'h789C;
            default: line = 16'hE0FD;
        endcase
        return line[(3-c)*4 +: 4];
`else
        return 4'(r * 4 + c);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_key(input int r, input int c);
        exp_q.push_back(exp_code(r, c));
        last_code = exp_code(r, c);
        n_exp++;
    endtask

    always @(negedge clk) begin
        if (reset && key_valid) begin
            check("key_valid_single_cycle", 32'(kv_prev), 32'd0);
            n_events++;
            if (exp_q.size() == 0) begin
                check("unexpected_key_valid", 32'(key_valid), 32'd0);
            end else begin
                check("key_code", 32'(key_code), 32'(exp_q.pop_front()));
            end
        end
        kv_prev = key_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] rb;
        int         nchg;
        int         r, c;

        pk        = '0;
        last_code = '0;
        reset     = 1'b0;
        step(2);
        check("reset_rows",      32'(rows),      32'hE);
        check("reset_key_code",  32'(key_code),  32'h0);
        check("reset_key_valid", 32'(key_valid), 32'h0);
        check("reset_key_held",  32'(key_held),  32'h0);

        // Idle scan: one row step every 4 cycles, wrapping back to row 0.
        @(negedge clk) reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check("idle_scan_rows", 32'(rows), 32'(4'(~(4'b1 << ((k / 4) % 4)))));
        end

        // Clean press of row2/col1, held long, then released.
        pk[2*4+1] = 1'b1;
        expect_key(2, 1);
        step(60);
        check("press_event_count", n_events, n_exp);
        check("press_held",        32'(key_held), 32'd1);
        step(60);
        check("no_repeat_while_held", n_events, n_exp);
        pk = '0;
        step(30);
        check("release_held",      32'(key_held), 32'd0);
        check("code_holds",        32'(key_code), 32'(last_code));

        // Bouncing press never stable for the debounce window.
        for (int i = 0; i < 14; i++) begin
            pk[2*4+1] = (i % 2 == 0);
            step(3);
        end
        pk = '0;
        step(12);
        check("bounce_no_event", n_events, n_exp);
        check("bounce_not_held", 32'(key_held), 32'd0);
        rb = rows;
        step(4);
        check("bounce_scan_resumes", 32'(rows), 32'({rb[2:0], rb[3]}));

        // Accepted key released through bounce bursts.
        pk[1*4+3] = 1'b1;
        expect_key(1, 3);
        step(50);
        check("bounce_rel_event", n_events, n_exp);
        for (int i = 0; i < 4; i++) begin
            pk = '0;
            step(3);
            pk[1*4+3] = 1'b1;
            step(2);
            check("held_during_bounce", 32'(key_held), 32'd1);
        end
        pk = '0;
        step(7);
        check("held_until_stable_release", 32'(key_held), 32'd1);
        step(13);
        check("held_drops_after_release", 32'(key_held), 32'd0);
        check("no_second_event", n_events, n_exp);

        // Two keys in one row: ignored, scanning keeps moving.
        pk[0] = 1'b1;
        pk[1] = 1'b1;
        nchg = 0;
        for (int i = 0; i < 40; i++) begin
            rb = rows;
            step(1);
            if (rows != rb) nchg++;
        end
        check("multikey_scan_continues", 32'(nchg >= 9), 32'd1);
        check("multikey_no_event", n_events, n_exp);
        pk = '0;
        step(10);

        // Asynchronous reset while a key is held.
        pk[3*4+0] = 1'b1;
        expect_key(3, 0);
        step(50);
        check("midrun_held", 32'(key_held), 32'd1);
        #3 reset = 1'b0;
        #1;
        check("async_reset_rows",      32'(rows),      32'hE);
        check("async_reset_key_code",  32'(key_code),  32'h0);
        check("async_reset_key_valid", 32'(key_valid), 32'h0);
        check("async_reset_key_held",  32'(key_held),  32'h0);
        last_code = '0;
        pk = '0;
        step(2);

        // Reset landing in the middle of debounce on row0/col2.
        @(negedge clk);
        reset = 1'b1;
        pk[0*4+2] = 1'b1;
        repeat (6) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("deb_reset_rows", 32'(rows),     32'hE);
        check("deb_reset_held", 32'(key_held), 32'h0);
        pk = '0;
        step(2);
        @(negedge clk) reset = 1'b1;
        step(20);
        check("deb_reset_no_strobe", n_events, n_exp);

        // Randomized clean presses anywhere on the pad.
        for (int i = 0; i < 10; i++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            pk = '0;
            pk[r*4+c] = 1'b1;
            expect_key(r, c);
            step(int'($urandom_range(45, 70)));
            check("rand_held", 32'(key_held), 32'd1);
            pk = '0;
            step(int'($urandom_range(20, 30)));
            check("rand_released", 32'(key_held), 32'd0);
            check("rand_code_holds", 32'(key_code), 32'(last_code));
        end

        check("total_events", n_events, n_exp);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
